// File: rtl/fwrisc_alu_pkg.sv
// fwrisc_alu_pkg: shared ALU opcode encodings and issue-request codes
package fwrisc_alu_pkg;
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_EQ   = 4'd5;
  localparam logic [3:0] OP_NE   = 4'd6;
  localparam logic [3:0] OP_LT   = 4'd7;
  localparam logic [3:0] OP_GE   = 4'd8;
  localparam logic [3:0] OP_LTU  = 4'd9;
  localparam logic [3:0] OP_GEU  = 4'd10;
  localparam logic [3:0] REQ_SLL = 4'd13;
  localparam logic [3:0] REQ_SRL = 4'd14;
  localparam logic [3:0] REQ_SRA = 4'd15;
  function automatic logic is_shift(input logic [3:0] op);
    return op == REQ_SLL || op == REQ_SRL || op == REQ_SRA;
  endfunction
endpackage

// File: rtl/fwrisc_alu.sv
// fwrisc_alu: combinational ALU, reserved opcodes yield zero
module fwrisc_alu
  import fwrisc_alu_pkg::*;
(
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [3:0]  op,
  output logic [31:0] result
);
  always_comb begin
    result = 32'd0;
    case (op)
      OP_ADD: result = op_a + op_b;
      OP_SUB: result = op_a - op_b;
      OP_AND: result = op_a & op_b;
      OP_OR:  result = op_a | op_b;
      OP_XOR: result = op_a ^ op_b;
      OP_EQ:  result = {31'd0, op_a == op_b};
      OP_NE:  result = {31'd0, op_a != op_b};
      OP_LT:  result = {31'd0, $signed(op_a) < $signed(op_b)};
      OP_GE:  result = {31'd0, $signed(op_a) >= $signed(op_b)};
      OP_LTU: result = {31'd0, op_a < op_b};
      OP_GEU: result = {31'd0, op_a >= op_b};
      default: result = 32'd0;
    endcase
  end
endmodule

// File: rtl/fwrisc_alu_issue.sv
// fwrisc_alu_issue: request/response wrapper sequencing an external ALU and serial shifts
module fwrisc_alu_issue
  import fwrisc_alu_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [31:0] alu_op_a,
  output logic [31:0] alu_op_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_out
);
  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, RESP} state_t;
  state_t state, state_nxt;
  logic [31:0] a, b, acc, acc_nxt;
  logic [3:0] op, sh_op;
  logic [4:0] cnt;
  logic sll_cyc, accept;
  always_comb begin
    state_nxt = state;
    sll_cyc = state == SHIFT && sh_op == REQ_SLL;
    accept = state == IDLE && req_valid;
    req_ready = state == IDLE && !reset;
    rsp_valid = state == RESP;
    alu_op_a = sll_cyc ? acc : a;
    alu_op_b = sll_cyc ? acc : b;
    alu_op = sll_cyc ? OP_ADD : op;
    acc_nxt = sh_op == REQ_SLL ? alu_out : sh_op == REQ_SRA ? {acc[31], acc[31:1]} : {1'b0, acc[31:1]};
    case (state)
      IDLE:  state_nxt = !req_valid ? IDLE : !is_shift(req_op) ? EXEC : req_b[4:0] == 5'd0 ? RESP : SHIFT;
      EXEC:  state_nxt = RESP;
      SHIFT: state_nxt = cnt == 5'd1 ? RESP : SHIFT;
      RESP:  state_nxt = rsp_ready ? IDLE : RESP;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      a <= '0;
      b <= '0;
      op <= '0;
      sh_op <= '0;
      acc <= '0;
      cnt <= '0;
      rsp_data <= '0;
    end else begin
      state <= state_nxt;
      if (accept && is_shift(req_op)) begin
        acc <= req_a;
        cnt <= req_b[4:0];
        sh_op <= req_op;
        rsp_data <= req_a;
      end else if (accept) begin
        a <= req_a;
        b <= req_b;
        op <= req_op;
      end
      if (state == EXEC) rsp_data <= alu_out;
      if (state == SHIFT) begin
        acc <= acc_nxt;
        cnt <= cnt - 5'd1;
        rsp_data <= acc_nxt;
      end
    end
  end
endmodule

// File: tb/tb_fwrisc_alu_issue.sv
// tb_fwrisc_alu_issue: directed self-checking bench for the ALU issue block
module tb_fwrisc_alu_issue;
  import fwrisc_alu_pkg::*;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [3:0] req_op = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic rsp_valid;
  logic rsp_ready = 1'b0;
  logic [31:0] rsp_data, alu_op_a, alu_op_b, alu_out;
  logic [3:0] alu_op;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clock = ~clock;
  fwrisc_alu_issue dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .alu_op_a(alu_op_a),
    .alu_op_b(alu_op_b), .alu_op(alu_op), .alu_out(alu_out)
  );
  fwrisc_alu u_alu (.op_a(alu_op_a), .op_b(alu_op_b), .op(alu_op), .result(alu_out));
  task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     output logic [31:0] d, output int lat);
    @(negedge clock);
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      @(posedge clock);
      #1;
      lat++;
    end
    if (!rsp_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout op=%0d: no rsp_valid within %0d cycles", op, lat);
    end
    d = rsp_data;
    @(posedge clock);
    #1;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    n_cmp++;
    if (req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    n_cmp++;
    if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++;
    if (rsp_data !== 32'd0) begin n_bad++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
    n_cmp++;
    if ({alu_op_a, alu_op_b, alu_op} !== 68'd0) begin
      n_bad++;
      $display("FAIL reset_alu_ports: got a=%h b=%h op=%h want zeros", alu_op_a, alu_op_b, alu_op);
    end
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_req_ready: got %b want 1", req_ready); end
  endtask
  task automatic test_alu();
    logic [3:0] ops[7] = '{OP_ADD, OP_LT, OP_LTU, OP_SUB, OP_XOR, OP_EQ, 4'd11};
    logic [31:0] as[7] = '{32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'd5, 32'hF0F0F0F0, 32'd3, 32'hDEADBEEF};
    logic [31:0] bs[7] = '{32'd1, 32'd1, 32'd1, 32'd7, 32'hFF00FF00, 32'd3, 32'h12345678};
    logic [31:0] ex[7] = '{32'h0, 32'h1, 32'h0, 32'hFFFFFFFE, 32'h0FF00FF0, 32'h1, 32'h0};
    logic [31:0] d;
    int lat;
    for (int i = 0; i < 7; i++) begin
      run(ops[i], as[i], bs[i], d, lat);
      n_cmp++;
      if (d !== ex[i]) begin n_bad++; $display("FAIL alu_data[%0d] op=%0d: got %h want %h", i, ops[i], d, ex[i]); end
      n_cmp++;
      if (lat !== 2) begin n_bad++; $display("FAIL alu_latency[%0d]: got %0d want 2", i, lat); end
    end
  endtask
  task automatic test_shift();
    logic [3:0] ops[5] = '{REQ_SLL, REQ_SRA, REQ_SRL, REQ_SRL, REQ_SLL};
    logic [31:0] as[5] = '{32'h3, 32'h80000000, 32'h80000000, 32'h12345678, 32'h40000001};
    logic [31:0] bs[5] = '{32'd4, 32'd31, 32'd31, 32'h20, 32'hFFFFFFE1};
    logic [31:0] ex[5] = '{32'h30, 32'hFFFFFFFF, 32'h1, 32'h12345678, 32'h80000002};
    int el[5] = '{5, 32, 32, 1, 2};
    logic [31:0] d;
    int lat;
    for (int i = 0; i < 5; i++) begin
      run(ops[i], as[i], bs[i], d, lat);
      n_cmp++;
      if (d !== ex[i]) begin n_bad++; $display("FAIL shift_data[%0d] op=%0d: got %h want %h", i, ops[i], d, ex[i]); end
      n_cmp++;
      if (lat !== el[i]) begin n_bad++; $display("FAIL shift_latency[%0d]: got %0d want %0d", i, lat, el[i]); end
    end
  endtask
  task automatic test_backpressure();
    int bad = 0;
    int wait_cyc = 0;
    @(negedge clock);
    req_valid = 1'b1;
    req_op = OP_ADD;
    req_a = 32'd10;
    req_b = 32'd20;
    rsp_ready = 1'b0;
    @(posedge clock);
    #1;
    req_op = OP_SUB;
    req_a = 32'd1;
    req_b = 32'd1;
    while (!rsp_valid && wait_cyc < 10) begin
      @(posedge clock);
      #1;
      wait_cyc++;
    end
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid !== 1'b1 || rsp_data !== 32'd30 || req_ready !== 1'b0) bad++;
      @(posedge clock);
      #1;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL hold_stable: %0d unstable cycles, last valid=%b data=%h ready=%b want 1/30/0", bad, rsp_valid, rsp_data, req_ready);
    end
    @(negedge clock);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    n_cmp++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL release: got valid=%b ready=%b want 0/1", rsp_valid, req_ready);
    end
  endtask
  task automatic test_back_to_back();
    logic [31:0] d;
    int lat;
    run(OP_OR, 32'h0000F000, 32'h0000000F, d, lat);
    n_cmp++;
    if (d !== 32'h0000F00F) begin n_bad++; $display("FAIL b2b_or: got %h want 0000f00f", d); end
    run(REQ_SRA, 32'hF0000000, 32'd4, d, lat);
    n_cmp++;
    if (d !== 32'hFF000000) begin n_bad++; $display("FAIL b2b_sra: got %h want ff000000", d); end
    run(OP_AND, 32'hFF00FF00, 32'h0FF00FF0, d, lat);
    n_cmp++;
    if (d !== 32'h0F000F00) begin n_bad++; $display("FAIL b2b_and: got %h want 0f000f00", d); end
  endtask
  task automatic test_reset_mid();
    int seen = 0;
    @(negedge clock);
    req_valid = 1'b1;
    req_op = REQ_SLL;
    req_a = 32'h1;
    req_b = 32'd20;
    rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    n_cmp++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || rsp_data !== 32'd0) begin
      n_bad++;
      $display("FAIL mid_reset: got valid=%b ready=%b data=%h want 0/0/0", rsp_valid, req_ready, rsp_data);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clock);
      #1;
      if (rsp_valid) seen++;
    end
    n_cmp++;
    if (seen != 0 || req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL abandon: got %0d response cycles ready=%b want 0 and 1", seen, req_ready);
    end
  endtask
  initial begin
    test_reset();
    test_alu();
    test_shift();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fwrisc_alu_issue.md
FWRISC_ALU_ISSUE -- requirements
Module: fwrisc_alu_issue

Interface
REQ-001 SHALL have ports: clock  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports: req_valid  input  1  request present.
REQ-004 SHALL have ports: req_ready  output  1  request accepted when req_valid && req_ready.
REQ-005 SHALL have ports: req_op  input  4  request opcode (ALU op codes, plus REQ_SLL/REQ_SRL/REQ_SRA).
REQ-006 SHALL have ports: req_a, req_b  input  32  operands; req_b[4:0] is the shift amount for shifts.
REQ-007 SHALL have ports: rsp_valid  output  1  result present.
REQ-008 SHALL have ports: rsp_ready  input  1  result consumed when rsp_valid && rsp_ready.
REQ-009 SHALL have ports: rsp_data  output  32  result.
REQ-010 SHALL have ports: alu_op_a, alu_op_b  output  32  and alu_op  output  4  which drive the external fwrisc_alu.
REQ-011 SHALL have ports: alu_out  input  32  combinational ALU result.

Function
REQ-012 SHALL implement FSM states IDLE, EXEC, SHIFT, RESP; req_ready=1 only in IDLE.
REQ-013 On acceptance with a non-shift req_op, SHALL register a, b and op, then go to EXEC.
REQ-014 In EXEC, SHALL drive alu_op_a=a, alu_op_b=b, alu_op=op; SHALL capture alu_out into rsp_data; SHALL go to RESP. rsp_valid rises 2 cycles after the accept edge.
REQ-015 Non-shift opcodes (including reserved codes) SHALL pass unchanged to alu_op; result semantics are the ALU's.
REQ-016 On acceptance with a shift opcode, SHALL load acc=req_a and cnt=req_b[4:0]. If cnt==0, SHALL go directly to RESP with rsp_data=req_a (rsp_valid 1 cycle after accept). Otherwise SHALL go to SHIFT.
REQ-017 In SHIFT, each cycle SHALL update acc and decrement cnt; when cnt==1, SHALL go to RESP with rsp_data=new acc. rsp_valid rises 1+shamt cycles after accept.
REQ-018 For SLL, SHALL compute acc via the ALU: alu_op=OP_ADD, alu_op_a=alu_op_b=acc, acc<=alu_out.
REQ-019 For SRL, SHALL use acc<=acc>>1 with zero fill. For SRA, SHALL use acc<=acc>>>1 with sign fill. Both are internal.
REQ-020 In IDLE, RESP and the SRL/SRA SHIFT cycles, alu_op_a/alu_op_b/alu_op SHALL hold the last registered values (no X).
REQ-021 rsp_valid and rsp_data SHALL stay stable in RESP until rsp_ready; SHALL go to IDLE on the handshake edge, with req_ready=1 the next cycle.
REQ-022 req_valid in non-IDLE states SHALL be ignored; req_* inputs SHALL be sampled only at acceptance.
REQ-023 Shift amounts SHALL use only 5 bits (req_b[31:5] ignored); shamt=31 SHALL take exactly 31 SHIFT cycles.

Reset
REQ-024 While reset=1 (synchronous), SHALL force state=IDLE, req_ready=0, rsp_valid=0, rsp_data=0, acc=0, cnt=0, and registered a/b/op=0 (alu_op_a/b=0, alu_op=0).
REQ-025 req_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-026 Reset asserted mid-EXEC/SHIFT/RESP SHALL abandon the operation with no response.

Structure
REQ-027 ALU op encodings (OP_ADD..OP_LTU, OP_XOR) and REQ_SLL/REQ_SRL/REQ_SRA SHALL live in shared package fwrisc_alu_pkg, used by this block and fwrisc_alu.
REQ-028 The FSM state enum SHALL be local to the module.
REQ-029 SHALL contain no sub-module; fwrisc_alu SHALL be instantiated alongside at the parent level, and the bench SHALL connect it the same way.

Verification
REQ-030 OP_ADD, a=0xFFFFFFFF, b=1 -> rsp_data=0x00000000, rsp_valid 2 cycles after accept.
REQ-031 OP_LT, a=0x80000000, b=1 -> 1; OP_LTU with the same operands -> 0.
REQ-032 REQ_SLL a=0x00000003, b=4 -> 0x00000030 after 5 cycles; REQ_SRA a=0x80000000, b=31 -> 0xFFFFFFFF; REQ_SRL same operands -> 0x00000001.
REQ-033 REQ_SRL b=0x00000020 (shamt 0) -> rsp_data=a, 1 cycle latency.
REQ-034 Hold rsp_ready=0 for 5 cycles -> rsp_valid/rsp_data stable, req_ready=0, extra req_valid ignored; back-to-back requests after release complete in order.
REQ-035 Assert reset during SHIFT (shamt 20) -> next cycle rsp_valid=0, state IDLE, no response emitted.
